// File: rtl/seq_shift_unit.sv
// Multi-cycle log shifter: one power-of-two stage per clock, start/ready/out_valid handshake.
// Define SEQ_SHIFT_ROTATE_EN to turn mode 2'b11 into rotate-left; otherwise it passes a through.
module seq_shift_unit #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned AMT_W = 32
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             start_i,
  input  logic [1:0]       mode_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [AMT_W-1:0] b_i,
  output logic             ready_o,
  output logic             busy_o,
  output logic             out_valid_o,
  output logic [WIDTH-1:0] result_o
);

  localparam int unsigned L = $clog2(WIDTH);

  typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

  state_e           state_q, state_d;
  logic [1:0]       mode_q, mode_d;
  logic [WIDTH-1:0] work_q, work_d;
  logic [L-1:0]     amt_q, amt_d;
  logic [L-1:0]     k_q, k_d;
  logic [L-1:0]     shamt;
  logic [WIDTH-1:0] stage_res;
  logic             out_of_range;

  assign out_of_range = (b_i >> L) != '0;
  assign shamt        = L'(1) << k_q;

`ifdef SEQ_SHIFT_ROTATE_EN
  logic [L:0] rshamt;
  assign rshamt = (L+1)'(WIDTH) - {1'b0, shamt};
`endif

  // Single shifter stage; the stage weight 2^k is selected by the counter.
  always_comb begin
    stage_res = work_q;
    if ((amt_q & shamt) != '0) begin
      unique case (mode_q)
        2'b00:   stage_res = work_q << shamt;
        2'b01:   stage_res = work_q >> shamt;
        2'b10:   stage_res = $unsigned($signed(work_q) >>> shamt);
`ifdef SEQ_SHIFT_ROTATE_EN
        default: stage_res = (work_q << shamt) | (work_q >> rshamt);
`else
        default: stage_res = work_q;
`endif
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      mode_q  <= '0;
      work_q  <= '0;
      amt_q   <= '0;
      k_q     <= '0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      work_q  <= work_d;
      amt_q   <= amt_d;
      k_q     <= k_d;
    end
  end

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    work_d  = work_q;
    amt_d   = amt_q;
    k_d     = k_q;
    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          mode_d  = mode_i;
          amt_d   = b_i[L-1:0];
          k_d     = '0;
          work_d  = a_i;
          state_d = StShift;
          // Oversized amounts saturate immediately; mode 11 (rotate/pass) never saturates.
          if (out_of_range && (mode_i != 2'b11)) begin
            work_d  = (mode_i == 2'b10) ? {WIDTH{a_i[WIDTH-1]}} : '0;
            state_d = StDone;
          end
        end
      end
      StShift: begin
        work_d = stage_res;
        k_d    = k_q + L'(1);
        if (k_q == L'(L - 1)) begin
          state_d = StDone;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    ready_o     = (state_q == StIdle);
    busy_o      = (state_q == StShift) || (state_q == StDone);
    out_valid_o = (state_q == StDone);
    result_o    = work_q;
  end

endmodule

// File: tb/tb_seq_shift_unit.sv
// Bench for seq_shift_unit: directed cases with literal expectations plus randomized traffic
// checked every cycle against an operation-level reference model.
module tb_seq_shift_unit;

  localparam int W = 32;
  localparam int L = 5;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [1:0]    mode = 2'b00;
  logic [W-1:0]  a = '0;
  logic [W-1:0]  b = '0;
  logic          ready, busy, out_valid;
  logic [W-1:0]  result;

  int checks = 0;
  int errors = 0;

  seq_shift_unit #(.WIDTH(W), .AMT_W(32)) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .start_i     (start),
    .mode_i      (mode),
    .a_i         (a),
    .b_i         (b),
    .ready_o     (ready),
    .busy_o      (busy),
    .out_valid_o (out_valid),
    .result_o    (result)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] ref_shift(input logic [1:0] m, input logic [W-1:0] x,
                                             input logic [W-1:0] amt);
    int s;
    if (m == 2'b11) begin
`ifdef SEQ_SHIFT_ROTATE_EN
      s = int'(amt % W);
      return (s == 0) ? x : ((x << s) | (x >> (W - s)));
`else
      return x;
`endif
    end
    if (amt >= W) return (m == 2'b10) ? {W{x[W-1]}} : '0;
    case (m)
      2'b00:   return x << amt;
      2'b01:   return x >> amt;
      default: return $unsigned($signed(x) >>> amt);
    endcase
  endfunction

  // Extra cycles between the accept edge and the out_valid cycle.
  function automatic int ref_lat(input logic [1:0] m, input logic [W-1:0] amt);
    return (m != 2'b11 && amt >= W) ? 0 : L;
  endfunction

  // Reference model: one pending operation with its completion cycle.
  bit           m_active = 0;
  int           m_cyc = 0;
  int           m_done = 0;
  logic [W-1:0] m_pend = '0;
  logic [W-1:0] m_last = '0;
  logic         e_ov;

  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
      chk("rst_result", result, 32'd0);
      m_active = 0;
      m_last   = '0;
      m_cyc    = 0;
    end else begin
      e_ov = m_active && (m_cyc == m_done);
      chk("ready", {31'd0, ready}, {31'd0, !m_active});
      chk("busy", {31'd0, busy}, {31'd0, m_active});
      chk("out_valid", {31'd0, out_valid}, {31'd0, e_ov});
      if (e_ov) chk("result_valid", result, m_pend);
      else if (!m_active) chk("result_idle", result, m_last);
      if (e_ov) begin
        m_active = 0;
        m_last   = m_pend;
      end else if (!m_active && start) begin
        m_active = 1;
        m_pend   = ref_shift(mode, a, b);
        m_done   = m_cyc + 1 + ref_lat(mode, b);
      end
      m_cyc++;
    end
  end

  task automatic wait_idle();
    int n = 0;
    @(negedge clk);
    while (!ready && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (!ready) chk("wait_idle_timeout", 32'd0, 32'd1);
  endtask

  // Holds start for exactly one edge; returns just after that (accept) edge.
  task automatic issue(input logic [1:0] m, input logic [W-1:0] x, input logic [W-1:0] amt);
    @(posedge clk);
    #1;
    start = 1'b1;
    mode  = m;
    a     = x;
    b     = amt;
    @(posedge clk);
    #1;
    start = 1'b0;
    mode  = 2'($urandom);
    a     = $urandom;
    b     = $urandom;
  endtask

  // Waits for out_valid; checks the result and, if exp_lat >= 0, cycles to pulse and busy count.
  task automatic wait_res(input string name, input logic [W-1:0] exp, input int exp_lat);
    int n = 0;
    int nb = 0;
    bit seen = 0;
    while (!seen && n < 40) begin
      @(negedge clk);
      n++;
      if (out_valid) seen = 1;
      else if (busy) nb++;
    end
    if (!seen) begin
      chk({name, "_timeout"}, 32'd0, 32'd1);
    end else begin
      chk(name, result, exp);
      if (exp_lat >= 0) begin
        chk({name, "_lat"}, n, exp_lat + 1);
        chk({name, "_busy"}, nb, exp_lat);
      end
    end
  endtask

  task automatic do_op(input string name, input logic [1:0] m, input logic [W-1:0] x,
                       input logic [W-1:0] amt, input logic [W-1:0] exp, input int exp_lat);
    wait_idle();
    issue(m, x, amt);
    wait_res(name, exp, exp_lat);
  endtask

  initial begin
    int ov_cnt;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // Abort mid-operation.
    wait_idle();
    issue(2'b00, 32'd1, 32'd3);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("abort_ready", {31'd0, ready}, 32'd1);
    chk("abort_result", result, 32'd0);
    ov_cnt = 0;
    repeat (8) begin
      @(negedge clk);
      if (out_valid) ov_cnt++;
    end
    chk("abort_no_pulse", ov_cnt, 0);

    do_op("sll_f1", 2'b00, 32'h0000_00F1, 32'd4, 32'h0000_0F10, 5);
    do_op("sra_31", 2'b10, 32'h8000_0000, 32'd31, 32'hFFFF_FFFF, 5);
    do_op("srl_31", 2'b01, 32'h8000_0000, 32'd31, 32'h0000_0001, 5);
    do_op("oor_sll", 2'b00, 32'hFFFF_FFFF, 32'd32, 32'h0000_0000, 0);
    do_op("oor_sra", 2'b10, 32'h8000_0001, 32'h0001_0000, 32'hFFFF_FFFF, 0);
    do_op("b_zero", 2'b10, 32'h8765_4321, 32'd0, 32'h8765_4321, 5);
`ifdef SEQ_SHIFT_ROTATE_EN
    do_op("rol_33", 2'b11, 32'h8000_0001, 32'd33, 32'h0000_0003, 5);
`else
    do_op("mode3_pass", 2'b11, 32'h1234_5678, 32'd7, 32'h1234_5678, 5);
`endif

    // Start while busy must be ignored, then an immediate back-to-back op.
    wait_idle();
    issue(2'b00, 32'd3, 32'd2);
    @(posedge clk);
    #1;
    start = 1'b1;
    mode  = 2'b01;
    a     = 32'hFFFF_0000;
    b     = 32'd1;
    @(posedge clk);
    #1 start = 1'b0;
    wait_res("busy_ignore", 32'h0000_000C, -1);
    issue(2'b01, 32'h0000_00F0, 32'd4);
    wait_res("back_to_back", 32'h0000_000F, 5);

    // Randomized traffic; the reference model checks every cycle.
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk);
      #1;
      start = ($urandom_range(0, 2) == 0);
      mode  = 2'($urandom);
      a     = $urandom;
      case ($urandom_range(0, 5))
        0:       b = $urandom;
        1:       b = 32'd32 + $urandom_range(0, 3);
        2:       b = 32'd31;
        default: b = $urandom_range(0, 31);
      endcase
    end
    @(posedge clk);
    #1 start = 1'b0;
    repeat (10) @(posedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
